// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
// Provides the controller state type, default sizing and address-split helpers.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } dcache_state_t;

    localparam int LINES_DEF = 16;
    localparam int CNT_W_DEF = 16;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Byte offset takes the low two address bits; the tag gets the rest above the index.
    function automatic int tag_w(input int lines);
        return 30 - $clog2(lines);
    endfunction

    // Both helpers return a 32-bit value; callers cast down to IDX_W / TAG_W.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int iw);
        return (addr >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int iw);
        return addr >> (iw + 2);
    endfunction

endpackage

// File: rtl/dcache_mem_if.sv
// Single-word request/acknowledge bus between the cache controller and main memory.
//   req   : request pending, held until ack
//   wr    : request is a write-back of wdata to addr
//   addr  : word-aligned byte address
//   wdata : write-back data
//   rdata : fill data, valid on the ack cycle
//   ack   : one-cycle acknowledge
interface dcache_mem_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, wr, addr, wdata, input rdata, ack);
    modport slave  (input req, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped cache: valid, dirty, tag and data per line.
//   clk_i, rst_i      : clock, synchronous active-high reset (clears valid/dirty only)
//   idx_i             : line index for both the combinational read and the write port
//   rd_*_o            : contents of line idx_i
//   data_we_i/wr_data_i : store data into the line
//   fill_we_i/fill_*_i  : install a line from memory (sets valid, loads tag and data)
//   dirty_set_i/dirty_clr_i : dirty-bit control, set has priority
module dcache_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             rd_valid_o,
    output logic             rd_dirty_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             data_we_i,
    input  logic [31:0]      wr_data_i,
    input  logic             fill_we_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [31:0]      fill_data_i,
    input  logic             dirty_set_i,
    input  logic             dirty_clr_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_we_i) begin
                valid_q[idx_i] <= 1'b1;
            end
            if (dirty_set_i) begin
                dirty_q[idx_i] <= 1'b1;
            end else if (dirty_clr_i) begin
                dirty_q[idx_i] <= 1'b0;
            end
        end
    end

    // Tag and data carry no reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_data_i;
        end else if (data_we_i) begin
            data_q[idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally in the request cycle; misses evict (if dirty) then fill.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   cache_req_i/wr_i  : access pending / access is a store (held while stalled)
//   addr_i, data_i    : byte address and store data
//   data_o, valid_o   : load data (0 unless valid_o) and completion strobe
//   mem               : main-memory request/ack bus (master side)
//   hit_cnt_o, miss_cnt_o : saturating hit and miss counters
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | serve hits; a miss latches index/tag and leaves IDLE
// EVICT | write back the dirty victim line, wait for ack
// FILL  | read the requested word from memory, install on ack
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cache_req_i,
    input  logic              wr_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              valid_o,
    dcache_mem_if.master      mem,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    dcache_state_t    state_q;
    logic [IDX_W-1:0] lat_idx_q;
    logic [TAG_W-1:0] lat_tag_q;
    logic             mem_req_q;
    logic             mem_wr_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_data_q;
    logic [CNT_W-1:0] hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] arr_idx;
    logic             rd_valid;
    logic             rd_dirty;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             miss;
    logic             data_we;
    logic             fill_we;
    logic             dirty_clr;

    assign req_idx = IDX_W'(addr_index(addr_i, IDX_W));
    assign req_tag = TAG_W'(addr_tag(addr_i, IDX_W));

    // Outside IDLE the array must follow the latched miss, not the live address.
    assign arr_idx = (state_q == IDLE) ? req_idx : lat_idx_q;

    assign hit  = ~rst_i & (state_q == IDLE) & cache_req_i & rd_valid & (rd_tag == req_tag);
    assign miss = ~rst_i & (state_q == IDLE) & cache_req_i & ~hit;

    assign data_we   = hit & wr_i;
    assign fill_we   = (state_q == FILL) & mem.ack;
    assign dirty_clr = ((state_q == EVICT) | (state_q == FILL)) & mem.ack;

    assign hit_cnt_d  = (hit  && (hit_cnt_q  != '1)) ? hit_cnt_q  + 1'b1 : hit_cnt_q;
    assign miss_cnt_d = (miss && (miss_cnt_q != '1)) ? miss_cnt_q + 1'b1 : miss_cnt_q;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (arr_idx),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .data_we_i   (data_we),
        .wr_data_i   (data_i),
        .fill_we_i   (fill_we),
        .fill_tag_i  (lat_tag_q),
        .fill_data_i (mem.rdata),
        .dirty_set_i (data_we),
        .dirty_clr_i (dirty_clr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lat_idx_q  <= '0;
            lat_tag_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        lat_idx_q <= req_idx;
                        lat_tag_q <= req_tag;
                        mem_req_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q    <= EVICT;
                            mem_wr_q   <= 1'b1;
                            mem_addr_q <= {rd_tag, req_idx, 2'b00};
                            mem_data_q <= rd_data;
                        end else begin
                            state_q    <= FILL;
                            mem_wr_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, 2'b00};
                            mem_data_q <= '0;
                        end
                    end
                end
                EVICT: begin
                    // Request stays high straight into the fill.
                    if (mem.ack) begin
                        state_q    <= FILL;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= {lat_tag_q, lat_idx_q, 2'b00};
                        mem_data_q <= '0;
                    end
                end
                FILL: begin
                    if (mem.ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o    = hit;
    assign data_o     = hit ? rd_data : '0;
    assign mem.req    = mem_req_q;
    assign mem.wr     = mem_wr_q;
    assign mem.addr   = mem_addr_q;
    assign mem.wdata  = mem_data_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule
